// File: rtl/div_ctrl_pkg.sv
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Opcode encodings, controller state encodings and opcode
//               decode helpers shared by the divide controller files.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package div_ctrl_pkg;

  localparam int OP_W = 8;

  // Divide-family opcode encodings
  localparam logic [OP_W-1:0] INST_DIV   = 8'h40;
  localparam logic [OP_W-1:0] INST_DIVU  = 8'h41;
  localparam logic [OP_W-1:0] INST_REM   = 8'h42;
  localparam logic [OP_W-1:0] INST_REMU  = 8'h43;
  localparam logic [OP_W-1:0] INST_DIVW  = 8'h44;
  localparam logic [OP_W-1:0] INST_DIVUW = 8'h45;
  localparam logic [OP_W-1:0] INST_REMW  = 8'h46;
  localparam logic [OP_W-1:0] INST_REMUW = 8'h47;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [63:0] ZERO_WORD  = 64'h0;

  // Most-negative dividends that overflow when divided by -1
  localparam logic [63:0] MIN_D = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

  // Controller state encodings
  localparam logic [2:0] DIVC_IDLE  = 3'd0;
  localparam logic [2:0] DIVC_START = 3'd1;
  localparam logic [2:0] DIVC_BUSY  = 3'd2;
  localparam logic [2:0] DIVC_FIX   = 3'd3;
  localparam logic [2:0] DIVC_DONE  = 3'd4;

  function automatic logic op_known(input logic [OP_W-1:0] op);
    return (op >= INST_DIV) && (op <= INST_REMUW);
  endfunction

  function automatic logic op_is_rem(input logic [OP_W-1:0] op);
    return (op == INST_REM) || (op == INST_REMU) ||
           (op == INST_REMW) || (op == INST_REMUW);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == INST_DIV) || (op == INST_REM) ||
           (op == INST_DIVW) || (op == INST_REMW);
  endfunction

  function automatic logic op_is_word(input logic [OP_W-1:0] op);
    return (op == INST_DIVW) || (op == INST_DIVUW) ||
           (op == INST_REMW) || (op == INST_REMUW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_ctrl_fixup.sv
// ============================================================================
// Module      : div_fixup
// Description : Turns the unsigned core quotient/remainder into the final
//               architectural result (sign fix-up and W-variant extension).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_fixup
  import div_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic [OPW-1:0]  opcode_i,
  input  logic            qneg_i,
  input  logic            rneg_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] rem_i,
  output logic [XLEN-1:0] result_o
);

  logic            is_rem_w;
  logic            neg_w;
  logic [XLEN-1:0] sel_w;
  logic [XLEN-1:0] val_w;

  // Pick quotient or remainder, restore its sign, then narrow W results
  always_comb begin
    is_rem_w = op_is_rem(opcode_i);
    sel_w    = is_rem_w ? rem_i : quot_i;
    neg_w    = op_is_signed(opcode_i) & (is_rem_w ? rneg_i : qneg_i);
    val_w    = neg_w ? (ZERO_WORD - sel_w) : sel_w;
    if (op_is_word(opcode_i)) begin
      result_o = {{(XLEN-32){val_w[31]}}, val_w[31:0]};
    end else begin
      result_o = val_w;
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : Sequencing controller between execute and the iterative
//               unsigned divider core. Prepares operands, resolves special
//               cases locally, runs the core and fixes up the result.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_opcode,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic            core_start,
  output logic            core_abort,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  input  logic            core_done,
  input  logic [XLEN-1:0] core_quot,
  input  logic [XLEN-1:0] core_rem
);

  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] dvd_q, dvs_q, quot_q, rem_q, res_q;
  logic            qneg_q, rneg_q;

  logic            accept_w;
  logic            is_w_w, is_s_w, is_r_w, known_w;
  logic            sa_w, sb_w, div0_w, ovf_w, special_w;
  logic [XLEN-1:0] ext1_w, ext2_w, abs1_w, abs2_w, spec_res_w, fix_res_w;

  assign req_ready     = (state_q == DIVC_IDLE) & ~flush & ~rst;
  assign accept_w      = req_valid & req_ready;
  assign busy          = (state_q != DIVC_IDLE);
  assign core_start    = (state_q == DIVC_START);
  // The core shares rst, so a reset never needs an abort
  assign core_abort    = flush & ~rst &
                         ((state_q == DIVC_START) | (state_q == DIVC_BUSY));
  assign resp_valid    = (state_q == DIVC_DONE);
  assign resp_data     = res_q;
  assign core_dividend = dvd_q;
  assign core_divisor  = dvs_q;

  // Operand extension, magnitudes and special-case detection at accept
  always_comb begin
    is_w_w  = op_is_word(req_opcode);
    is_s_w  = op_is_signed(req_opcode);
    is_r_w  = op_is_rem(req_opcode);
    known_w = op_known(req_opcode);
    if (is_w_w) begin
      ext1_w = {{(XLEN-32){is_s_w & req_src1[31]}}, req_src1[31:0]};
      ext2_w = {{(XLEN-32){is_s_w & req_src2[31]}}, req_src2[31:0]};
    end else begin
      ext1_w = req_src1;
      ext2_w = req_src2;
    end
    sa_w   = is_s_w & ext1_w[XLEN-1];
    sb_w   = is_s_w & ext2_w[XLEN-1];
    abs1_w = sa_w ? (ZERO_WORD - ext1_w) : ext1_w;
    abs2_w = sb_w ? (ZERO_WORD - ext2_w) : ext2_w;
    div0_w = (ext2_w == ZERO_WORD);
    ovf_w  = is_s_w && (ext2_w == {XLEN{1'b1}}) &&
             (ext1_w == (is_w_w ? MIN_W : MIN_D));
    special_w  = ~known_w | div0_w | ovf_w;
    spec_res_w = ZERO_WORD;
    if (!known_w) begin
      spec_res_w = ZERO_WORD;
    end else if (div0_w) begin
      spec_res_w = is_r_w ? ext1_w : {XLEN{1'b1}};
    end else if (ovf_w) begin
      spec_res_w = is_r_w ? ZERO_WORD : ext1_w;
    end
  end

  // Next-state selection; flush overrides every other event
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DIVC_IDLE;
    end else begin
      case (state_q)
        DIVC_IDLE:  if (accept_w) state_d = special_w ? DIVC_DONE : DIVC_START;
        DIVC_START: state_d = DIVC_BUSY;
        DIVC_BUSY:  if (core_done) state_d = DIVC_FIX;
        DIVC_FIX:   state_d = DIVC_DONE;
        DIVC_DONE:  if (resp_ready) state_d = DIVC_IDLE;
        default:    state_d = DIVC_IDLE;
      endcase
    end
  end

  div_fixup #(
    .XLEN (XLEN),
    .OPW  (OPW)
  ) u_fixup (
    .opcode_i (op_q),
    .qneg_i   (qneg_q),
    .rneg_i   (rneg_q),
    .quot_i   (quot_q),
    .rem_i    (rem_q),
    .result_o (fix_res_w)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= DIVC_IDLE;
      op_q    <= '0;
      dvd_q   <= ZERO_WORD;
      dvs_q   <= ZERO_WORD;
      quot_q  <= ZERO_WORD;
      rem_q   <= ZERO_WORD;
      res_q   <= ZERO_WORD;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_w) begin
        op_q   <= req_opcode;
        dvd_q  <= abs1_w;
        dvs_q  <= abs2_w;
        qneg_q <= sa_w ^ sb_w;
        rneg_q <= sa_w;
        if (special_w) res_q <= spec_res_w;
      end
      if ((state_q == DIVC_BUSY) && core_done && !flush) begin
        quot_q <= core_quot;
        rem_q  <= core_rem;
      end
      if ((state_q == DIVC_FIX) && !flush) begin
        res_q <= fix_res_w;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module      : tb_div_ctrl
// Description : Directed, table-driven bench for div_ctrl with a simple
//               fixed-latency divider core model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0]  req_opcode;
  logic [63:0] req_src1, req_src2, resp_data;
  logic        busy, core_start, core_abort, core_done;
  logic [63:0] core_dividend, core_divisor;
  logic [63:0] core_quot = 64'h0;
  logic [63:0] core_rem  = 64'h0;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(64), .OPW(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .core_start(core_start), .core_abort(core_abort),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_done(core_done), .core_quot(core_quot), .core_rem(core_rem)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Core model: done pulses L cycles after the start cycle
  int          core_lat   = 3;
  int          cnt        = 0;
  int          n_starts   = 0;
  logic [63:0] seen_dvd   = 64'h0;
  logic [63:0] seen_dvs   = 64'h1;
  logic        model_done = 1'b0;
  logic        inj_done   = 1'b0;
  assign core_done = model_done | inj_done;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        model_done = 1'b1;
        core_quot  = seen_dvd / seen_dvs;
        core_rem   = seen_dvd % seen_dvs;
      end
    end
    #2;
    if (rst || core_abort) cnt = 0;
    else if (core_start) begin
      cnt      = core_lat;
      n_starts = n_starts + 1;
      seen_dvd = core_dividend;
      seen_dvs = core_divisor;
    end
  end

  typedef struct {
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] exp;
    bit          st;
    logic [63:0] dvd;
    logic [63:0] dvs;
  } vec_t;

  vec_t vecs[16];
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic do_req(input string nm, input logic [7:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int lat, input logic [63:0] exp,
                        input bit st, input logic [63:0] edvd, input logic [63:0] edvs,
                        input int hold);
    int s0, n;
    bit got;
    @(negedge clk);
    core_lat = lat; s0 = n_starts;
    req_valid = 1'b1; req_opcode = op; req_src1 = a; req_src2 = b;
    #1 chk({nm, "_ready"}, {63'h0, req_ready}, 64'h1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      #1;
      if (resp_valid) begin got = 1'b1; n = i; break; end
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(n), st ? 64'(3 + lat) : 64'h1);
    chk({nm, "_data"}, resp_data, exp);
    chk({nm, "_starts"}, 64'(n_starts - s0), st ? 64'h1 : 64'h0);
    if (st) begin
      chk({nm, "_dividend"}, seen_dvd, edvd);
      chk({nm, "_divisor"}, seen_dvs, edvs);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk({nm, "_hold"}, {resp_data[61:0], resp_valid, req_ready},
          {exp[61:0], 1'b1, 1'b0});
    end
    @(negedge clk); resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    #1 chk({nm, "_idle"}, {61'h0, busy, resp_valid, req_ready}, 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{INST_DIV,   64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64, 64'hFFFF_FFFF_FFFF_FFFA, 1, 64'd20, 64'd3};
    vecs[1]  = '{INST_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3, ONES, 1, 64'd7, 64'd2};
    vecs[2]  = '{INST_REMU,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2};
    vecs[3]  = '{INST_DIVU,  64'd123, 64'd0, 0, ONES, 0, 64'd0, 64'd0};
    vecs[4]  = '{INST_REM,   64'h8000_0000_0000_0000, ONES, 0, 64'd0, 0, 64'd0, 64'd0};
    vecs[5]  = '{INST_DIVUW, 64'h1_8000_0000, 64'd1, 2, 64'hFFFF_FFFF_8000_0000, 1, 64'h8000_0000, 64'd1};
    vecs[6]  = '{INST_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFF_8000_0000, 0, 64'd0, 64'd0};
    vecs[7]  = '{INST_DIV,   64'h8000_0000_0000_0000, ONES, 0, 64'h8000_0000_0000_0000, 0, 64'd0, 64'd0};
    vecs[8]  = '{INST_REMW,  64'hFFFF_FFF9, 64'd2, 1, ONES, 1, 64'd7, 64'd2};
    vecs[9]  = '{INST_DIVW,  64'd7, 64'hFFFF_FFFF_0000_0000, 0, ONES, 0, 64'd0, 64'd0};
    vecs[10] = '{INST_REMUW, 64'h5_0000_000A, 64'h3_0000_0003, 4, 64'd1, 1, 64'hA, 64'd3};
    vecs[11] = '{8'hFF,      64'd5, 64'd3, 0, 64'd0, 0, 64'd0, 64'd0};
    vecs[12] = '{INST_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 0, 64'd0, 64'd0};
    vecs[13] = '{INST_DIVU,  64'd100, 64'd7, 1, 64'd14, 1, 64'd100, 64'd7};
    vecs[14] = '{INST_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 6, 64'd14, 1, 64'd100, 64'd7};
    vecs[15] = '{INST_DIVUW, 64'hFFFF_FFFE, 64'd1, 2, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'hFFFF_FFFE, 64'd1};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_opcode = 8'h0; req_src1 = 64'h0; req_src2 = 64'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk("rst_req_ready_low", {63'h0, req_ready}, 64'h0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_req_ready_high", {63'h0, req_ready}, 64'h1);
    chk("rst_outputs", {60'h0, resp_valid, busy, core_start, core_abort}, 64'h0);
    chk("rst_resp_data", resp_data, 64'h0);

    for (int i = 0; i < 16; i++) begin
      do_req($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].exp, vecs[i].st, vecs[i].dvd, vecs[i].dvs, 0);
    end

    // Back-pressure: result held for 5 cycles
    do_req("hold", INST_REMU, 64'd17, 64'd5, 2, 64'd2, 1, 64'd17, 64'd5, 5);

    // Flush in BUSY coinciding with core_done
    begin
      bit seen;
      @(negedge clk);
      core_lat = 4; req_valid = 1'b1; req_opcode = INST_DIV; req_src1 = 64'd20; req_src2 = 64'd3;
      @(negedge clk); req_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk); flush = 1'b1;
      #1 chk("flushbusy_abort", {63'h0, core_abort}, 64'h1);
      @(negedge clk); flush = 1'b0;
      #1 chk("flushbusy_after", {60'h0, core_abort, busy, resp_valid, req_ready}, 64'h1);
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk); #1;
        if (resp_valid) seen = 1'b1;
      end
      chk("flushbusy_no_resp", {63'h0, seen}, 64'h0);
    end
    do_req("after_flush", INST_DIV, 64'd20, 64'd3, 2, 64'd6, 1, 64'd20, 64'd3, 0);

    // Flush in START
    @(negedge clk);
    core_lat = 3; req_valid = 1'b1; req_opcode = INST_DIVU; req_src1 = 64'd9; req_src2 = 64'd3;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    #1 chk("flushstart_pulses", {62'h0, core_start, core_abort}, 64'h3);
    @(negedge clk); flush = 1'b0;
    #1 chk("flushstart_idle", {62'h0, busy, core_abort}, 64'h0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid = 1'b1; req_opcode = INST_DIVU; req_src1 = 64'd1; req_src2 = 64'd1; flush = 1'b1;
    #1 chk("flushidle_ready", {63'h0, req_ready}, 64'h0);
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;
    #1 chk("flushidle_not_accepted", {63'h0, busy}, 64'h0);

    // Flush in DONE drops resp_valid
    @(negedge clk);
    req_valid = 1'b1; req_opcode = INST_DIVU; req_src1 = 64'd5; req_src2 = 64'd0;
    @(negedge clk); req_valid = 1'b0;
    #1 chk("flushdone_valid", {63'h0, resp_valid}, 64'h1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk("flushdone_dropped", {62'h0, busy, resp_valid}, 64'h0);

    // Stray core_done in IDLE is ignored
    @(negedge clk); inj_done = 1'b1;
    #1 chk("stray_done_during", {63'h0, busy}, 64'h0);
    @(negedge clk); inj_done = 1'b0;
    #1 chk("stray_done_after", {62'h0, busy, resp_valid}, 64'h0);

    // Reset mid-operation: no abort, all state cleared
    @(negedge clk);
    core_lat = 20; req_valid = 1'b1; req_opcode = INST_DIVU; req_src1 = 64'd100; req_src2 = 64'd7;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_no_abort", {63'h0, core_abort}, 64'h0);
    @(negedge clk); rst = 1'b0;
    #1 chk("midrst_idle", {61'h0, busy, resp_valid, req_ready}, 64'h1);
    chk("midrst_data", resp_data, 64'h0);
    do_req("after_rst", INST_REMW, 64'hFFFF_FFF9, 64'hFFFF_FFFD, 3, 64'hFFFF_FFFF_FFFF_FFFF,
           1, 64'd7, 64'd3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
